// File: rtl/clock_display_driver.sv
// Multiplexed 6-digit HH:MM:SS common-anode 7-segment driver with per-frame time snapshot.
// Optional 12-hour display with PM dot on hours-ones when H12_MODE_EN is defined.
module clock_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned    DivW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SegDash = 7'b0111111;

    logic [DivW-1:0] r_div;
    logic [2:0]      r_idx;
    logic [5:0]      r_sec;
    logic [5:0]      r_min;
    logic [4:0]      r_hr;
    logic [5:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic            w_wrap;
    logic            w_sec_ok;
    logic            w_min_ok;
    logic            w_hr_ok;
    logic            w_pm;
    logic [4:0]      w_hr_disp;
    logic [5:0]      w_hr_disp6;
    logic [5:0]      w_digit;
    logic            w_dash;
    logic [5:0]      w_an;

    function automatic logic [6:0] f_seg(input logic [5:0] d);
        case (d)
            6'd0:    f_seg = 7'b1000000;
            6'd1:    f_seg = 7'b1111001;
            6'd2:    f_seg = 7'b0100100;
            6'd3:    f_seg = 7'b0110000;
            6'd4:    f_seg = 7'b0011001;
            6'd5:    f_seg = 7'b0010010;
            6'd6:    f_seg = 7'b0000010;
            6'd7:    f_seg = 7'b1111000;
            6'd8:    f_seg = 7'b0000000;
            6'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    assign w_wrap   = (r_div == DivMax);
    assign w_sec_ok = (r_sec <= 6'd59);
    assign w_min_ok = (r_min <= 6'd59);
    assign w_hr_ok  = (r_hr <= 5'd23);

`ifdef H12_MODE_EN
    always_comb begin
        w_hr_disp = r_hr;
        if (r_hr == 5'd0) begin
            w_hr_disp = 5'd12;
        end else if (r_hr > 5'd12) begin
            w_hr_disp = r_hr - 5'd12;
        end
    end
    assign w_pm = w_hr_ok && (r_hr >= 5'd12);
`else
    assign w_hr_disp = r_hr;
    assign w_pm      = 1'b0;
`endif

    assign w_hr_disp6 = {1'b0, w_hr_disp};

    always_comb begin
        w_digit = 6'd0;
        w_dash  = 1'b0;
        w_an    = 6'b111111;
        case (r_idx)
            3'd0: begin
                w_digit = r_sec % 6'd10;
                w_dash  = ~w_sec_ok;
                w_an    = 6'b111110;
            end
            3'd1: begin
                w_digit = r_sec / 6'd10;
                w_dash  = ~w_sec_ok;
                w_an    = 6'b111101;
            end
            3'd2: begin
                w_digit = r_min % 6'd10;
                w_dash  = ~w_min_ok;
                w_an    = 6'b111011;
            end
            3'd3: begin
                w_digit = r_min / 6'd10;
                w_dash  = ~w_min_ok;
                w_an    = 6'b110111;
            end
            3'd4: begin
                w_digit = w_hr_disp6 % 6'd10;
                w_dash  = ~w_hr_ok;
                w_an    = 6'b101111;
            end
            3'd5: begin
                w_digit = w_hr_disp6 / 6'd10;
                w_dash  = ~w_hr_ok;
                w_an    = 6'b011111;
            end
            default: begin
                w_digit = 6'd0;
                w_dash  = 1'b1;
                w_an    = 6'b111111;
            end
        endcase
    end

    // Shadow registers only load at the 5->0 wrap so a frame never mixes two times.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_idx <= 3'd0;
            r_sec <= 6'd0;
            r_min <= 6'd0;
            r_hr  <= 5'd0;
        end else begin
            if (w_wrap) begin
                r_div <= '0;
                if (r_idx == 3'd5) begin
                    r_idx <= 3'd0;
                    r_sec <= sec;
                    r_min <= min;
                    r_hr  <= hr;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= 6'b111111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= en ? w_an : 6'b111111;
            r_seg <= w_dash ? SegDash : f_seg(w_digit);
            r_dp  <= ~(w_pm && (r_idx == 3'd4));
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver at REFRESH_DIV=4; hour expectations follow H12_MODE_EN.
module tb_clock_display_driver;

    localparam int unsigned Div = 4;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] sb_q[$];
    logic [6:0]  seg_tbl[10];

    clock_display_driver #(
        .REFRESH_DIV(Div)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .sec    (sec),
        .min    (min),
        .hr     (hr),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got an/seg/dp=%b/%b/%b want %b/%b/%b", tag,
                     got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
        end
    endtask

    // Expected {an, seg, dp} for one digit given the snapshot the frame is showing.
    function automatic logic [13:0] model(input int idx, input int s, input int m, input int h,
                                          input logic en_v);
        int         v;
        bit         ok;
        int         d;
        logic       p;
        logic [6:0] sg;
        logic [5:0] one;
        logic [5:0] a;
        p = 1'b1;
        v = 0;
        ok = 1'b1;
        case (idx / 2)
            0: begin v = s; ok = (s <= 59); end
            1: begin v = m; ok = (m <= 59); end
            default: begin
                v  = h;
                ok = (h <= 23);
`ifdef H12_MODE_EN
                if (h == 0) v = 12;
                else if (h > 12) v = h - 12;
                if (ok && h >= 12 && idx == 4) p = 1'b0;
`endif
            end
        endcase
        d   = (idx % 2 == 1) ? (v / 10) : (v % 10);
        sg  = ok ? seg_tbl[d] : 7'b0111111;
        one = 6'b000001;
        a   = en_v ? ~(one << idx) : 6'b111111;
        return {a, sg, p};
    endfunction

    // Runs one 6-digit frame starting just before its first clock edge.
    task automatic run_frame(input int s, input int m, input int h, input logic en_v,
                             input int chg_idx, input int chg_sec);
        logic [13:0] exp;
        en = en_v;
        for (int i = 0; i < 6; i++) sb_q.push_back(model(i, s, m, h, en_v));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp = sb_q.pop_front();
            check_eq($sformatf("frame_%0d_%0d_%0d_idx%0d", h, m, s, i), {an, seg, dp}, exp);
            if (i == chg_idx) sec = 6'(chg_sec);
            repeat (Div - 1) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_time(input int s, input int m, input int h);
        sec = 6'(s);
        min = 6'(m);
        hr  = 5'(h);
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        reset_n = 1'b0;
        en      = 1'b0;
        set_time(0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("reset_hold", {an, seg, dp}, {6'b111111, 7'b1111111, 1'b1});

        set_time(58, 59, 23);
        en      = 1'b1;
        reset_n = 1'b1;
        run_frame(0, 0, 0, 1'b1, -1, 0);
        run_frame(58, 59, 23, 1'b1, 2, 59);
        set_time(61, 5, 7);
        run_frame(59, 59, 23, 1'b1, -1, 0);
        run_frame(61, 5, 7, 1'b1, -1, 0);
        set_time(10, 30, 0);
        run_frame(61, 5, 7, 1'b0, -1, 0);
        set_time(0, 0, 13);
        run_frame(10, 30, 0, 1'b1, -1, 0);
        set_time(1, 2, 25);
        run_frame(0, 0, 13, 1'b1, -1, 0);
        run_frame(1, 2, 25, 1'b1, -1, 0);

        // Abort mid-frame; reset must take effect without a clock edge.
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("reset_async", {an, seg, dp}, {6'b111111, 7'b1111111, 1'b1});
        repeat (2) @(negedge clk);
        check_eq("reset_mid_hold", {an, seg, dp}, {6'b111111, 7'b1111111, 1'b1});
        reset_n = 1'b1;
        run_frame(0, 0, 0, 1'b1, -1, 0);
        run_frame(1, 2, 25, 1'b1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
